// File: rtl/store_buffer.sv
// Store buffer: holds completed stores until the ROB commits them in order, drains
// committed stores to memory one at a time, and forwards buffered data to loads.
module store_buffer #(
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [WORD_SIZE-1:0]       st_addr,
    input  logic [WORD_SIZE-1:0]       st_data,
    input  logic [RB_INDEX-1:0]        st_rb_index,
    output logic                       st_ready,
    input  logic                       commit_valid,
    input  logic [RB_INDEX-1:0]        commit_rb_index,
    output logic                       commit_miss,
    input  logic                       flush,
    output logic                       mem_we,
    output logic [WORD_SIZE-1:0]       mem_addr,
    output logic [WORD_SIZE-1:0]       mem_wdata,
    input  logic                       mem_ack,
    input  logic [WORD_SIZE-1:0]       ld_addr,
    output logic                       ld_hit,
    output logic [WORD_SIZE-1:0]       ld_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_SIZE-1:0]  addr_q [DEPTH];
    logic [WORD_SIZE-1:0]  data_q [DEPTH];
    logic [RB_INDEX-1:0]   tag_q  [DEPTH];
    logic [DEPTH-1:0]      committed_q;
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         ccount_q;
    logic                  commit_miss_q;

    logic                  push, pop;
    logic                  commit_hit, commit_miss_d;
    logic [PW-1:0]         uc_idx;

    assign st_ready    = (count_q != CW'(DEPTH));
    assign count       = count_q;
    assign commit_miss = commit_miss_q;

    assign push = st_valid && st_ready && !flush;
    assign pop  = (state_q == S_WRITE) && mem_ack;

    // Commits arrive in order, so committed entries always form a prefix from head;
    // the oldest uncommitted entry therefore sits ccount_q slots past head.
    assign uc_idx        = head_q + ccount_q[PW-1:0];
    assign commit_hit    = commit_valid && !flush && (ccount_q != count_q) &&
                           (tag_q[uc_idx] == commit_rb_index);
    assign commit_miss_d = commit_valid && !flush && !commit_hit;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            tag_q[tail_q]  <= st_rb_index;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ccount_q      <= '0;
            committed_q   <= '0;
            commit_miss_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            commit_miss_q <= commit_miss_d;

            if (commit_hit) committed_q[uc_idx] <= 1'b1;
            if (pop)        committed_q[head_q] <= 1'b0;
            if (push)       committed_q[tail_q] <= 1'b0;

            if (pop) head_q <= head_q + 1'b1;

            // Flush truncates the FIFO just past the committed prefix; a same-cycle
            // pop shortens that prefix from the head side only.
            if (flush) begin
                tail_q  <= head_q + ccount_q[PW-1:0];
                count_q <= ccount_q - CW'(pop);
            end else begin
                if (push) tail_q <= tail_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end

            ccount_q <= ccount_q + CW'(commit_hit) - CW'(pop);
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && committed_q[head_q]) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q[head_q];
                mem_wdata = data_q[head_q];
                if (mem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[head_q + PW'(k)];
            end
        end
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data/address width.
REQ-002 SHALL have parameter RB_INDEX, default 4, reorder-buffer tag width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port st_valid  input  1  storer presents a completed store.
REQ-007 SHALL have port st_addr  input  WORD_SIZE  store address.
REQ-008 SHALL have port st_data  input  WORD_SIZE  store data.
REQ-009 SHALL have port st_rb_index  input  RB_INDEX  ROB tag of the store.
REQ-010 SHALL have port st_ready  output  1  buffer not full.
REQ-011 SHALL have port commit_valid  input  1  ROB commits a store this cycle.
REQ-012 SHALL have port commit_rb_index  input  RB_INDEX  tag being committed.
REQ-013 SHALL have port commit_miss  output  1  one-cycle pulse, commit tag mismatched.
REQ-014 SHALL have port flush  input  1  discard all uncommitted entries.
REQ-015 SHALL have port mem_we  output  1  memory write request.
REQ-016 SHALL have port mem_addr  output  WORD_SIZE  write address.
REQ-017 SHALL have port mem_wdata  output  WORD_SIZE  write data.
REQ-018 SHALL have port mem_ack  input  1  memory accepted write.
REQ-019 SHALL have port ld_addr  input  WORD_SIZE  load forwarding lookup address.
REQ-020 SHALL have port ld_hit  output  1  a buffered store matches ld_addr.
REQ-021 SHALL have port ld_data  output  WORD_SIZE  forwarded data.
REQ-022 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-023 SHALL hold entries in a circular FIFO (head, tail, count) with per-entry addr, data, tag, committed flag.
REQ-024 SHALL push at posedge when st_valid && st_ready && !flush; st_ready = (count != DEPTH), from registered count.
REQ-025 SHALL, on commit_valid, set committed on the oldest uncommitted entry iff its tag equals commit_rb_index; otherwise pulse commit_miss next cycle and change nothing.
REQ-026 SHALL treat commit of a tag being pushed the same cycle as a miss.
REQ-027 SHALL run drain FSM IDLE->WRITE->IDLE: IDLE goes to WRITE when head entry valid and committed; WRITE drives mem_we=1 with head addr/data held stable until mem_ack sampled 1, then pops head and returns to IDLE.
REQ-028 SHALL give minimum 2 cycles per drained store; mem_we=0, mem_addr/mem_wdata=0 in IDLE.
REQ-029 SHALL allow push and pop in the same cycle; count unchanged.
REQ-030 SHALL, on flush, set tail = head + committed-entry count; committed entries and an in-flight WRITE are unaffected; flush overrides a same-cycle push and commit.
REQ-031 SHALL wrap head/tail modulo DEPTH.
REQ-032 SHALL compute ld_hit/ld_data combinationally: youngest valid entry (committed or not) with addr == ld_addr; ld_data=0 when no hit.

Reset
REQ-033 SHALL on reset: head=tail=count=0, all entries invalid/uncommitted, FSM IDLE, mem_we=0, mem_addr=0, mem_wdata=0, commit_miss=0, st_ready=1; reset during WRITE abandons the write.

Verification
REQ-034 SHALL pass: push (0x10,0xAA,tag 3), commit 3, mem_ack after 2 cycles -> mem_we held 3 cycles with 0x10/0xAA, count returns 0.
REQ-035 SHALL pass: push DEPTH entries -> st_ready=0, further push ignored, count=DEPTH; one drain -> st_ready=1.
REQ-036 SHALL pass: push tags 1,2; commit 2 -> commit_miss pulses, no mem_we; commit 1 then 2 -> two writes in order.
REQ-037 SHALL pass: push tags 1,2,3, commit 1, flush -> count=1, entry tag 1 drains, tags 2,3 never written.
REQ-038 SHALL pass: push (0x20,0x1) then (0x20,0x2), ld_addr=0x20 -> ld_hit=1, ld_data=0x2; ld_addr=0x24 -> ld_hit=0, ld_data=0.
REQ-039 SHALL pass: reset asserted mid-WRITE -> mem_we=0 immediately, count=0, st_ready=1.
